// File: rtl/snoop_bus_pkg.sv
// Shared types and constants for the two-core snoop bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package snoop_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int OP_W   = 2;

    // Core identifiers as used by the owner / last_owner registers
    localparam logic CORE1 = 1'b0;
    localparam logic CORE2 = 1'b1;

    typedef enum logic [OP_W-1:0] {
        NONE     = 2'b00,
        BUS_RD   = 2'b01,
        BUS_UPGR = 2'b10,
        BUS_RDX  = 2'b11
    } bus_op_t;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        SNOOP,
        WAIT_FLUSH,
        DONE
    } arb_state_t;

endpackage

// File: rtl/snoop_rr_pick.sv
// Two-way round-robin pick: the core that did not own the bus last wins a tie.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is taken.
module snoop_rr_pick
    import snoop_bus_pkg::*;
(
    input  logic req_core1,
    input  logic req_core2,
    input  logic last_owner,
    output logic pick_vld,
    output logic pick_owner
);

    // Single requester wins outright; on a tie the previous owner yields
    always_comb begin
        pick_vld   = req_core1 | req_core2;
        pick_owner = CORE1;
        if (req_core1 && req_core2) begin
            pick_owner = (last_owner == CORE1) ? CORE2 : CORE1;
        end else if (req_core2) begin
            pick_owner = CORE2;
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter: grants one core, broadcasts its op/address to the other core, collects hit/flush.
// Latency: grant 1 cycle after request; snoop outputs 1 cycle after op; DONE SNOOP_LAT cycles later (+flush).
// Backpressure: requests wait until IDLE; a flushing snooper stalls the transaction. SNOOP_ARB_TIMEOUT_EN adds a grant hold limit.
module snoop_bus_arbiter
    import snoop_bus_pkg::*;
#(
    parameter int SNOOP_LAT = 1,
    parameter int MAX_HOLD  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_core1,
    input  logic              req_core2,
    output logic              grant_core1,
    output logic              grant_core2,
    input  logic [OP_W-1:0]   bus_operation_in1,
    input  logic [OP_W-1:0]   bus_operation_in2,
    input  logic [ADDR_W-1:0] bus_address_in1,
    input  logic [ADDR_W-1:0] bus_address_in2,
    output logic [OP_W-1:0]   snoop_operation_out1,
    output logic [OP_W-1:0]   snoop_operation_out2,
    output logic [ADDR_W-1:0] snoop_address_out1,
    output logic [ADDR_W-1:0] snoop_address_out2,
    input  logic              cache_hit_in1,
    input  logic              cache_hit_in2,
    input  logic              flush_in1,
    input  logic              flush_in2,
    output logic              shared_out1,
    output logic              shared_out2,
    output logic              txn_done,
    output logic              busy,
    output logic              timeout_err
);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              grant1_q, grant1_d, grant2_q, grant2_d;
    bus_op_t           snp_op1_q, snp_op1_d, snp_op2_q, snp_op2_d;
    logic [ADDR_W-1:0] snp_addr1_q, snp_addr1_d, snp_addr2_q, snp_addr2_d;
    logic              shared1_q, shared1_d, shared2_q, shared2_d;
    logic              txn_done_q, txn_done_d;
    logic [2:0]        snp_cnt_q, snp_cnt_d;

    logic              pick_vld, pick_owner;
    bus_op_t           own_op;
    logic [ADDR_W-1:0] own_addr;
    logic              own_req, snp_hit, snp_flush;

`ifdef SNOOP_ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic       hold_expire;
    logic       timeout_q, timeout_d;
`else
    // Without the hold counter the limit has no effect
    logic unused_max_hold;
    assign unused_max_hold = (MAX_HOLD > 0);
`endif

    snoop_rr_pick u_pick (
        .req_core1  (req_core1),
        .req_core2  (req_core2),
        .last_owner (last_owner_q),
        .pick_vld   (pick_vld),
        .pick_owner (pick_owner)
    );

    // Owner-side inputs and snooper-side responses, steered by the current owner
    assign own_op    = (owner_q == CORE2) ? bus_op_t'(bus_operation_in2) : bus_op_t'(bus_operation_in1);
    assign own_addr  = (owner_q == CORE2) ? bus_address_in2 : bus_address_in1;
    assign own_req   = (owner_q == CORE2) ? req_core2 : req_core1;
    assign snp_hit   = (owner_q == CORE2) ? cache_hit_in1 : cache_hit_in2;
    assign snp_flush = (owner_q == CORE2) ? flush_in1 : flush_in2;

`ifdef SNOOP_ARB_TIMEOUT_EN
    // Saturating grant hold counter; zeroed as a new grant is issued
    always_comb begin
        hold_d = hold_q;
        if (state_d == GRANT && state_q != GRANT) begin
            hold_d = 8'd0;
        end else if (state_q == GRANT && hold_q != 8'hFF) begin
            hold_d = hold_q + 8'd1;
        end
    end
    assign hold_expire = ({1'b0, hold_q} + 9'd1) >= 9'(MAX_HOLD);
`endif

    // Transaction sequencer: next state and next values of every output register
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant1_d     = grant1_q;
        grant2_d     = grant2_q;
        snp_op1_d    = snp_op1_q;
        snp_op2_d    = snp_op2_q;
        snp_addr1_d  = snp_addr1_q;
        snp_addr2_d  = snp_addr2_q;
        shared1_d    = shared1_q;
        shared2_d    = shared2_q;
        snp_cnt_d    = snp_cnt_q;
`ifdef SNOOP_ARB_TIMEOUT_EN
        timeout_d    = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d   = GRANT;
                    owner_d   = pick_owner;
                    grant1_d  = (pick_owner == CORE1);
                    grant2_d  = (pick_owner == CORE2);
                    shared1_d = 1'b0;
                    shared2_d = 1'b0;
                end
            end
            GRANT: begin
                if (own_op != NONE) begin
                    state_d   = SNOOP;
                    snp_cnt_d = 3'd0;
                    if (owner_q == CORE1) begin
                        snp_op2_d   = own_op;
                        snp_addr2_d = own_addr;
                    end else begin
                        snp_op1_d   = own_op;
                        snp_addr1_d = own_addr;
                    end
                end else if (!own_req) begin
                    state_d = DONE;
                end
`ifdef SNOOP_ARB_TIMEOUT_EN
                else if (hold_expire) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
`endif
            end
            SNOOP: begin
                if (snp_cnt_q == 3'(SNOOP_LAT - 1)) begin
                    if (owner_q == CORE1) shared1_d = snp_hit;
                    else                  shared2_d = snp_hit;
                    state_d = snp_flush ? WAIT_FLUSH : DONE;
                end else begin
                    snp_cnt_d = snp_cnt_q + 3'd1;
                end
            end
            WAIT_FLUSH: begin
                if (!snp_flush) state_d = DONE;
            end
            DONE: begin
                state_d      = IDLE;
                last_owner_d = owner_q;
            end
            default: state_d = IDLE;
        endcase
        // Entering DONE drops the grant and the broadcast in one place
        if (state_d == DONE) begin
            grant1_d    = 1'b0;
            grant2_d    = 1'b0;
            snp_op1_d   = NONE;
            snp_op2_d   = NONE;
            snp_addr1_d = '0;
            snp_addr2_d = '0;
        end
        txn_done_d = (state_d == DONE);
    end

    // State and output registers; reset aborts any transaction without a done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= CORE1;
            last_owner_q <= CORE2;
            grant1_q     <= 1'b0;
            grant2_q     <= 1'b0;
            snp_op1_q    <= NONE;
            snp_op2_q    <= NONE;
            snp_addr1_q  <= '0;
            snp_addr2_q  <= '0;
            shared1_q    <= 1'b0;
            shared2_q    <= 1'b0;
            txn_done_q   <= 1'b0;
            snp_cnt_q    <= 3'd0;
`ifdef SNOOP_ARB_TIMEOUT_EN
            hold_q       <= 8'd0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant1_q     <= grant1_d;
            grant2_q     <= grant2_d;
            snp_op1_q    <= snp_op1_d;
            snp_op2_q    <= snp_op2_d;
            snp_addr1_q  <= snp_addr1_d;
            snp_addr2_q  <= snp_addr2_d;
            shared1_q    <= shared1_d;
            shared2_q    <= shared2_d;
            txn_done_q   <= txn_done_d;
            snp_cnt_q    <= snp_cnt_d;
`ifdef SNOOP_ARB_TIMEOUT_EN
            hold_q       <= hold_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    assign grant_core1          = grant1_q;
    assign grant_core2          = grant2_q;
    assign snoop_operation_out1 = snp_op1_q;
    assign snoop_operation_out2 = snp_op2_q;
    assign snoop_address_out1   = snp_addr1_q;
    assign snoop_address_out2   = snp_addr2_q;
    assign shared_out1          = shared1_q;
    assign shared_out2          = shared2_q;
    assign txn_done             = txn_done_q;
    assign busy                 = (state_q != IDLE);
`ifdef SNOOP_ARB_TIMEOUT_EN
    assign timeout_err          = timeout_q;
`else
    assign timeout_err          = 1'b0;
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter (SNOOP_LAT=1, MAX_HOLD=4); timeout checks follow SNOOP_ARB_TIMEOUT_EN.
// Latency: one vector per clock; outputs sampled 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_snoop_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_core1, req_core2;
    logic        grant_core1, grant_core2;
    logic [1:0]  bus_operation_in1, bus_operation_in2;
    logic [31:0] bus_address_in1, bus_address_in2;
    logic [1:0]  snoop_operation_out1, snoop_operation_out2;
    logic [31:0] snoop_address_out1, snoop_address_out2;
    logic        cache_hit_in1, cache_hit_in2, flush_in1, flush_in2;
    logic        shared_out1, shared_out2, txn_done, busy, timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    snoop_bus_arbiter #(.SNOOP_LAT(1), .MAX_HOLD(4)) dut (
        .clk                  (clk),
        .reset                (reset),
        .req_core1            (req_core1),
        .req_core2            (req_core2),
        .grant_core1          (grant_core1),
        .grant_core2          (grant_core2),
        .bus_operation_in1    (bus_operation_in1),
        .bus_operation_in2    (bus_operation_in2),
        .bus_address_in1      (bus_address_in1),
        .bus_address_in2      (bus_address_in2),
        .snoop_operation_out1 (snoop_operation_out1),
        .snoop_operation_out2 (snoop_operation_out2),
        .snoop_address_out1   (snoop_address_out1),
        .snoop_address_out2   (snoop_address_out2),
        .cache_hit_in1        (cache_hit_in1),
        .cache_hit_in2        (cache_hit_in2),
        .flush_in1            (flush_in1),
        .flush_in2            (flush_in2),
        .shared_out1          (shared_out1),
        .shared_out2          (shared_out2),
        .txn_done             (txn_done),
        .busy                 (busy),
        .timeout_err          (timeout_err)
    );

    typedef struct packed {
        logic        r1, r2;
        logic [1:0]  o1, o2;
        logic [31:0] a1, a2;
        logic        h1, h2, f1, f2;
        logic        g1, g2;
        logic [1:0]  so1, so2;
        logic [31:0] sa1, sa2;
        logic        sh1, sh2, td, bz;
    } vec_t;

    vec_t tv [19];

    function automatic logic [74:0] outs();
        return {grant_core1, grant_core2, snoop_operation_out1, snoop_operation_out2,
                snoop_address_out1, snoop_address_out2, shared_out1, shared_out2,
                txn_done, busy, timeout_err};
    endfunction

    function automatic logic [74:0] mk(input logic g1, g2, input logic [1:0] so1, so2,
                                       input logic [31:0] sa1, sa2,
                                       input logic sh1, sh2, td, bz, te);
        return {g1, g2, so1, so2, sa1, sa2, sh1, sh2, td, bz, te};
    endfunction

    task automatic check(input string name, input logic [74:0] act, input logic [74:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        req_core1 = v.r1;          req_core2 = v.r2;
        bus_operation_in1 = v.o1;  bus_operation_in2 = v.o2;
        bus_address_in1 = v.a1;    bus_address_in2 = v.a2;
        cache_hit_in1 = v.h1;      cache_hit_in2 = v.h2;
        flush_in1 = v.f1;          flush_in2 = v.f2;
    endtask

    task automatic idle_inputs();
        vec_t z;
        z = '0;
        drive(z);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Core1 RD 0x40, core2 UPGR with hit, tie to core1, queued core2, abandon
        tv[0]  = '{r1:1, o1:2'b01, a1:32'h40, g1:1, bz:1, default:0};
        tv[1]  = '{r1:1, o1:2'b01, a1:32'h40, g1:1, so2:2'b01, sa2:32'h40, bz:1, default:0};
        tv[2]  = '{td:1, bz:1, default:0};
        tv[3]  = '{default:0};
        tv[4]  = '{r2:1, o2:2'b10, a2:32'h1234_5678, o1:2'b11, a1:32'h0000_dead, g2:1, bz:1, default:0};
        tv[5]  = '{r2:1, o2:2'b10, a2:32'h1234_5678, o1:2'b11, a1:32'h0000_dead, g2:1,
                   so1:2'b10, sa1:32'h1234_5678, bz:1, default:0};
        tv[6]  = '{h1:1, o1:2'b11, a1:32'h0000_dead, td:1, sh2:1, bz:1, default:0};
        tv[7]  = '{sh2:1, default:0};
        tv[8]  = '{r1:1, r2:1, o1:2'b11, a1:32'h80, o2:2'b01, a2:32'h100, g1:1, bz:1, default:0};
        tv[9]  = '{r1:1, r2:1, o1:2'b11, a1:32'h80, o2:2'b01, a2:32'h100, g1:1,
                   so2:2'b11, sa2:32'h80, bz:1, default:0};
        tv[10] = '{r2:1, o2:2'b01, a2:32'h100, td:1, bz:1, default:0};
        tv[11] = '{r2:1, o2:2'b01, a2:32'h100, default:0};
        tv[12] = '{r2:1, o2:2'b01, a2:32'h100, g2:1, bz:1, default:0};
        tv[13] = '{r2:1, o2:2'b01, a2:32'h100, g2:1, so1:2'b01, sa1:32'h100, bz:1, default:0};
        tv[14] = '{td:1, bz:1, default:0};
        tv[15] = '{default:0};
        tv[16] = '{r1:1, g1:1, bz:1, default:0};
        tv[17] = '{td:1, bz:1, default:0};
        tv[18] = '{default:0};

        do_reset();
        check("reset_state", outs(), '0);

        for (int i = 0; i < 19; i++) begin
            drive(tv[i]);
            tick();
            check($sformatf("vec%0d", i), outs(),
                  mk(tv[i].g1, tv[i].g2, tv[i].so1, tv[i].so2, tv[i].sa1, tv[i].sa2,
                     tv[i].sh1, tv[i].sh2, tv[i].td, tv[i].bz, 1'b0));
        end

        // Both cores request continuously: period of 4 cycles, owners alternate
        do_reset();
        req_core1 = 1'b1; req_core2 = 1'b1;
        bus_operation_in1 = 2'b01; bus_operation_in2 = 2'b01;
        bus_address_in1 = 32'h200; bus_address_in2 = 32'h300;
        for (int k = 1; k <= 16; k++) begin
            logic eg1, eg2, ebz;
            tick();
            eg1 = ((k % 4 == 1) || (k % 4 == 2)) && (((k - 1) / 4) % 2 == 0);
            eg2 = ((k % 4 == 1) || (k % 4 == 2)) && (((k - 1) / 4) % 2 == 1);
            ebz = (k % 4 != 0);
            n_cmp++;
            if ({grant_core1, grant_core2, busy} !== {eg1, eg2, ebz}) begin
                n_bad++;
                $display("FAIL rr_cycle%0d: g1/g2/busy got %b%b%b expected %b%b%b",
                         k, grant_core1, grant_core2, busy, eg1, eg2, ebz);
            end
            n_cmp++;
            if (grant_core1 && grant_core2) begin
                n_bad++;
                $display("FAIL rr_excl%0d: both grants high, expected at most one", k);
            end
        end

        // Core2 RDX, core1 hits and flushes for 5 cycles
        do_reset();
        req_core2 = 1'b1; bus_operation_in2 = 2'b11; bus_address_in2 = 32'hCAFE_0000;
        tick();
        check("flush_grant", outs(), mk(0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0));
        tick();
        check("flush_bcast", outs(), mk(0, 1, 2'b11, 2'b00, 32'hCAFE_0000, 0, 0, 0, 0, 1, 0));
        req_core2 = 1'b0; bus_operation_in2 = 2'b00;
        cache_hit_in1 = 1'b1; flush_in1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("flush_wait%0d", i), outs(),
                  mk(0, 1, 2'b11, 2'b00, 32'hCAFE_0000, 0, 0, 1, 0, 1, 0));
        end
        cache_hit_in1 = 1'b0; flush_in1 = 1'b0;
        tick();
        check("flush_done", outs(), mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1, 1, 0));
        tick();
        check("flush_idle", outs(), mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 0));

        // Complete a core1 transaction so last_owner is core1, then reset mid-SNOOP
        do_reset();
        req_core1 = 1'b1;
        tick();
        req_core1 = 1'b0;
        tick();
        tick();
        req_core1 = 1'b1; bus_operation_in1 = 2'b01; bus_address_in1 = 32'h44;
        tick();
        tick();
        check("rst_pre_snoop", outs(), mk(1, 0, 2'b00, 2'b01, 0, 32'h44, 0, 0, 0, 1, 0));
        #2 reset = 1'b1;
        #1 check("rst_async", outs(), '0);
        tick();
        check("rst_hold0", outs(), '0);
        tick();
        check("rst_hold1", outs(), '0);
        reset = 1'b0;
        req_core1 = 1'b1; req_core2 = 1'b1;
        bus_operation_in1 = 2'b01; bus_operation_in2 = 2'b01;
        tick();
        check("rst_tie_core1", outs(), mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0));

        // Grant held with op 00 and request high
        do_reset();
        req_core1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("hold%0d", i), outs(), mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0));
        end
        tick();
`ifdef SNOOP_ARB_TIMEOUT_EN
        check("tmo_done", outs(), mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 1));
        req_core1 = 1'b0;
        tick();
        check("tmo_sticky", outs(), mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1));
`else
        check("hold_no_tmo", outs(), mk(1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 0));
        req_core1 = 1'b0;
        tick();
        check("hold_abandon", outs(), mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0));
        tick();
        check("hold_idle", outs(), '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

- Owns the shared snoop bus between the two cores.
- Grants the bus to one requester at a time using round-robin on ties.
- Latches the owner's bus operation and address and broadcasts them to the other core's cache for snooping.
- Collects that core's hit/flush response, reports sharing back to the owner and closes the transaction.
- Sits between both processors' cache controllers and the bus data path; sequences every coherence transaction.

## Interface
Parameters:
- SNOOP_LAT, 1: cycles the snoop broadcast is held before the snooper response is sampled (1..7).
- MAX_HOLD, 8: cycles an owner may hold a grant without issuing an operation (1..255); used only with SNOOP_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_core1 / req_core2  in  1  bus request from each core, level, held until granted.
- grant_core1 / grant_core2  out  1  registered grant; at most one high.
- bus_operation_in1 / bus_operation_in2  in  2  owner operation: 00 NONE, 01 BUS_RD, 10 BUS_UPGR, 11 BUS_RDX.
- bus_address_in1 / bus_address_in2  in  32  owner address.
- snoop_operation_out1 / snoop_operation_out2  out  2  operation broadcast to the non-owner core.
- snoop_address_out1 / snoop_address_out2  out  32  address broadcast to the non-owner core.
- cache_hit_in1 / cache_hit_in2  in  1  snooper holds the line.
- flush_in1 / flush_in2  in  1  snooper is flushing a dirty line; level, held until the flush completes.
- shared_out1 / shared_out2  out  1  to the owner: line present in the other cache; valid from DONE until the next grant.
- txn_done  out  1  one-cycle pulse at transaction end.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky; set on a grant timeout.

## Operation
FSM states: IDLE, GRANT, SNOOP, WAIT_FLUSH, DONE.
- **IDLE:** no grant. If any request is high, pick a winner and go to GRANT.
  - Single requester wins.
  - If both request, the core that is not `last_owner` wins.
  - The grant register is set on the same edge.
- **GRANT:** owner's grant is high.
  - Owner op != 00: latch op and address, go to SNOOP. Snooper's snoop_operation_out/snoop_address_out load on the same edge.
  - Owner request drops with op == 00: go to DONE (abandoned; shared_out stays 0).
  - Hold counter reaches MAX_HOLD: go to DONE and set timeout_err (only with SNOOP_ARB_TIMEOUT_EN).
- **SNOOP:** broadcast held for SNOOP_LAT cycles. On the last of those cycles, sample the snooper's cache_hit_in and flush_in:
  - cache_hit_in loads shared_out of the owner.
  - flush high: go to WAIT_FLUSH.
  - flush low: go to DONE.
- **WAIT_FLUSH:** broadcast held. When the snooper's flush_in goes low, go to DONE.
- **DONE:**
  - Grant low, snoop outputs 00/0, txn_done = 1.
  - last_owner is updated to the owner.
  - Go to IDLE.
- Only the non-owner's snoop outputs are ever nonzero. The owner's snoop outputs stay 00/0.
- Input operations from the non-owner are ignored.
- A new request arriving during a transaction waits. It is served on the first IDLE cycle after DONE.

## Timing
- Reset (async):
  - Outputs: all 0.
  - Internal state: state = IDLE, last_owner = core2 (core1 wins the first tie), counters = 0, timeout_err = 0.
- Reset mid-transaction: aborts immediately. No txn_done pulse.
- Request seen in IDLE at cycle 0: grant high in cycle 1.
- Op sampled at edge N: snoop outputs valid from cycle N+1 for SNOOP_LAT cycles.
- Minimum transaction with no flush: grant cycle 1, op at cycle 1, SNOOP in cycle 2, DONE in cycle 2+SNOOP_LAT, IDLE after that. With SNOOP_LAT=1 that is 4 cycles from request to IDLE.
- Back-to-back requests: one IDLE cycle separates grants, so bus turnaround is one cycle.
- The hold counter is 8 bits, clears on entry to GRANT and saturates. It does not wrap.
- Simultaneous flush fall and reset: reset wins.

## Configuration
- SNOOP_ARB_TIMEOUT_EN defined: the MAX_HOLD counter is built, and a stalled GRANT is forced to DONE with timeout_err set.
- Not defined: GRANT waits indefinitely, the counter is not built and timeout_err is tied to 0.

## Structure
- Package snoop_bus_pkg holds:
  - bus_op_t enum: NONE, BUS_RD, BUS_UPGR, BUS_RDX.
  - arb_state_t enum.
  - Width constants: ADDR_W=32, OP_W=2.
- One sub-module, snoop_rr_pick: combinational two-way round-robin selection from req_core1, req_core2 and last_owner.

## Test plan
- Reset, then req_core1=1 with op 01 at addr 0x0000_0040 in the grant cycle:
  - grant_core1=1 at cycle 1.
  - snoop_operation_out2=01, snoop_address_out2=0x40 at cycle 2.
  - txn_done at cycle 3.
- Both requests high continuously:
  - Grants alternate 1,2,1,2.
  - Exactly one idle cycle between grants.
  - grant_core1 and grant_core2 never both high.
- Core2 owns with op 11; core1 drives cache_hit_in1=1 and flush_in1 high for 5 cycles:
  - State remains WAIT_FLUSH through those 5 cycles.
  - shared_out2=1.
  - txn_done one cycle after flush falls.
- With SNOOP_ARB_TIMEOUT_EN, MAX_HOLD=4, grant core1 held with op 00:
  - Forced DONE after 4 cycles.
  - timeout_err=1 and stays set.
- Reset asserted while in SNOOP:
  - All outputs 0 asynchronously.
  - No txn_done pulse.
  - First tie after release goes to core1.
- Core1 request drops with op 00 while granted: DONE next cycle, shared_out1=0, no snoop broadcast.
